// File: rtl/fft8_input_loader_pkg.sv
// Shared definitions for the 8-point radix-2 FFT datapath: sample layout,
// frame geometry, slot reordering and twiddle constants.
package fft8_input_loader_pkg;

  localparam int CPLX_W = 16;
  localparam int RE_MSB = 15;
  localparam int RE_LSB = 8;
  localparam int IM_MSB = 7;
  localparam int IM_LSB = 0;

  localparam int N     = 8;
  localparam int LOG2N = 3;

  // W8^k packed as {re, im}, Q1.6 (64 represents 1.0)
  localparam logic [CPLX_W-1:0] TW_W0 = 16'h4000;
  localparam logic [CPLX_W-1:0] TW_W1 = 16'h2DD3;
  localparam logic [CPLX_W-1:0] TW_W2 = 16'h00C0;
  localparam logic [CPLX_W-1:0] TW_W3 = 16'hD3D3;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] a);
    return {a[0], a[1], a[2]};
  endfunction

endpackage

// File: rtl/fft8_input_loader_if.sv
// Handshake bundle for the loader: serial sample input, parallel frame output.
interface fft8_input_loader_if
  import fft8_input_loader_pkg::*;
#(
  parameter int DW = CPLX_W
);
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [8*DW-1:0] m_frame;
  logic            err_align;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_frame, err_align
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_frame, err_align
  );
endinterface

// File: rtl/fft8_frame_bank.sv
// One frame buffer: eight DW-bit slots, single addressed write port and
// full parallel read-out.
module fft8_frame_bank
  import fft8_input_loader_pkg::*;
#(
  parameter int DW = CPLX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [LOG2N-1:0] addr,
  input  logic [DW-1:0]    wdata,
  output logic [N*DW-1:0]  frame
);

  logic [DW-1:0] slots [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) slots[k] <= '0;
    end else if (we) begin
      slots[addr] <= wdata;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_rd
    assign frame[DW*k +: DW] = slots[k];
  end

endmodule

// File: rtl/fft8_input_loader.sv
// FFT input stage: gathers 8 serial samples into a ping-pong frame buffer and
// hands complete frames to the butterfly stage in parallel.
module fft8_input_loader
  import fft8_input_loader_pkg::*;
#(
  parameter int DW     = CPLX_W,
  parameter bit BITREV = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  fft8_input_loader_if.slave  bus
);

  logic [1:0]       full, full_nxt;
  logic             wr_bank, rd_bank;
  logic [LOG2N-1:0] cnt;
  logic             err_q;

  logic             accept, xfer, at_end, early_last, complete, store;
  logic [LOG2N-1:0] addr;
  logic [N*DW-1:0]  frame0, frame1;

  assign accept     = bus.s_valid & bus.s_ready;
  assign xfer       = bus.m_valid & bus.m_ready;
  assign at_end     = (cnt == LOG2N'(N - 1));
  assign early_last = accept & ~at_end & bus.s_last;
  assign complete   = accept & at_end;
  assign store      = accept & ~early_last;
  assign addr       = BITREV ? bitrev3(cnt) : cnt;

  assign bus.s_ready   = ~rst & ~full[wr_bank];
  assign bus.m_valid   = full[rd_bank];
  assign bus.m_frame   = rd_bank ? frame1 : frame0;
  assign bus.err_align = err_q;

  // Completion and transfer always target different banks, so both updates apply.
  always_comb begin
    full_nxt = full;
    if (complete) full_nxt[wr_bank] = 1'b1;
    if (xfer)     full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      full  <= full_nxt;
      err_q <= early_last | (complete & ~bus.s_last);
      if (accept) cnt <= early_last ? '0 : cnt + LOG2N'(1);
      if (complete) wr_bank <= ~wr_bank;
      if (xfer)     rd_bank <= ~rd_bank;
    end
  end

  fft8_frame_bank #(.DW(DW)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (store & ~wr_bank),
    .addr  (addr),
    .wdata (bus.s_data),
    .frame (frame0)
  );

  fft8_frame_bank #(.DW(DW)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (store & wr_bank),
    .addr  (addr),
    .wdata (bus.s_data),
    .frame (frame1)
  );

endmodule

// File: doc/fft8_input_loader.md
Name: fft8_input_loader

Overview:
- Input stage of the 8-point radix-2 FFT datapath. It accepts a serial stream of packed complex samples over a valid/ready handshake.
- Collects each group of 8 samples into a frame, optionally in bit-reversed slot order.
- Presents each completed frame in parallel (slots 0..7) to the combinational butterfly stage through a valid/ready handshake.
- Ping-pong (two-bank) buffering: one frame fills while the previous one is held for the butterfly stage.

Parameters:
- DW, 16, packed complex sample width: re = [15:8], im = [7:0], each signed two's complement.
- BITREV, 1, 1 = sample n written to slot bitrev3(n); 0 = sample n written to slot n.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample this cycle.
- s_data  in  DW  packed complex input sample.
- s_last  in  1  marks the 8th sample of a frame.
- m_valid  out  1  a complete frame is presented on m_frame.
- m_ready  in  1  butterfly stage consumes the frame this cycle.
- m_frame  out  8*DW  slot k at [DW*k+DW-1 : DW*k]; maps to stage inputs i0..i7.
- err_align  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset: this is synchronous, active-high reset; one clock.
  - All of the following clear: both bank-full flags, wr_bank, rd_bank, sample count cnt (3 bits), and all bank data registers.
  - m_valid=0, m_frame=0, err_align=0.
  - s_ready=0 while rst is high and 1 in the first cycle after rst deasserts.
- Handshakes:
  - Accept = s_valid & s_ready.
  - Frame transfer = m_valid & m_ready.
  - s_ready = !rst & !full[wr_bank].
  - m_valid = full[rd_bank].
  - m_frame = contents of bank[rd_bank], muxed from registers with no combinational path from inputs.
  - m_frame is held stable while m_valid=1 and m_ready=0.
- Accept, cnt<7, s_last=0: write s_data into bank[wr_bank] at slot addr(cnt); cnt <= cnt+1.
  - addr(cnt) = bitrev3(cnt) if BITREV, else cnt.
  - bitrev3 mapping: 0->0, 1->4, 2->2, 3->6, 4->1, 5->5, 6->3, 7->7.
- Accept, cnt==7: write the slot; full[wr_bank] <= 1; wr_bank toggles; cnt <= 0.
  - If s_last==0, err_align pulses for 1 cycle. The frame is still delivered.
- Accept, cnt<7, s_last=1 (early last): the sample is discarded and the partial frame is dropped.
  - cnt <= 0; bank not marked full; wr_bank unchanged; err_align pulses for 1 cycle.
  - Stale data in the dropped bank is overwritten by the next frame.
- Transfer: full[rd_bank] <= 0; rd_bank toggles.
- Latency: m_valid rises the cycle after the 8th sample is accepted, provided that bank was the read bank.
- Throughput:
  - Sustained 1 sample/cycle as long as each frame is taken within 8 cycles of becoming valid.
  - When both banks are full, s_ready=0 until a transfer.
- Simultaneous completion (write to bank A) and transfer (read of bank B) in the same cycle: both take effect. The same bank can never be in both roles.
- Transfer while the other bank is full: m_valid stays 1 and m_frame switches to the other bank on the next cycle.
- Reset mid-frame: the partial frame and any pending frames are discarded; nothing is emitted.
- cnt wraps naturally 7->0. No overflow state exists.

Decomposition:
- Shared fft package holds:
  - complex sample width and re/im field positions;
  - frame size N=8 and log2N=3;
  - bitrev3 function;
  - twiddle constants used by the butterfly stages.
- One natural sub-module: fft8_frame_bank, one bank of 8 DW-bit registers with write-enable, 3-bit slot address, and parallel read-out. It is instantiated twice.
- Control (cnt, wr_bank, rd_bank, full flags, err logic) stays in the top level.

Test Plan:
- Basic load, BITREV=1, m_ready=1:
  - Stimulus: samples n=0..7 with s_data=16'h1000+n, s_last on n=7.
  - Response: m_valid=1 one cycle after the last accept; slot0=16'h1000, slot1=16'h1004, slot4=16'h1001, slot6=16'h1003; err_align=0.
- Natural order, BITREV=0: same stimulus -> slot k=16'h1000+k.
- Backpressure:
  - Stimulus: m_ready=0 while streaming 24 samples (3 frames) back-to-back.
  - Response: s_ready falls after the 16th accept; frame 1 holds stable; m_ready pulsed once -> frame 2 presented next cycle and s_ready=1 again; all 24 samples delivered in order.
- Early last:
  - Stimulus: s_last=1 on the 4th sample (cnt=3).
  - Response: err_align pulses once; no m_valid; the next 8 samples form a correct frame.
- Missing last: 8 samples with s_last=0 -> err_align pulses on the 8th accept and the frame is still delivered intact.
- Reset mid-operation:
  - Stimulus: rst for 1 cycle after 5 samples with one full frame pending.
  - Response: m_valid=0, m_frame=0, s_ready=0 during rst and 1 after; the next 8 samples produce a frame starting at slot0=sample 0.
